// File: rtl/mem_lsu.sv
// Memory-access stage of the yadan pipeline: one outstanding req/ack data-bus
// transfer per load/store, a pipeline stall while it is in flight, and an extended load result.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic        wb_stall_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic        dbus_err_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] EXE_LB  = 8'h20;
    localparam logic [7:0] EXE_LH  = 8'h21;
    localparam logic [7:0] EXE_LW  = 8'h22;
    localparam logic [7:0] EXE_LBU = 8'h23;
    localparam logic [7:0] EXE_LHU = 8'h24;
    localparam logic [7:0] EXE_SB  = 8'h28;
    localparam logic [7:0] EXE_SH  = 8'h29;
    localparam logic [7:0] EXE_SW  = 8'h2a;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // dbg_state encoding: 0 idle, 1 request in flight, 2 result presented.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        is_load, is_store, is_mem;
    logic        sz_byte, sz_half, sext;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    logic [7:0]  to_cnt;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        ld_q, sz_byte_q, sz_half_q, sext_q;
    logic [1:0]  addr_lo_q;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // ---------------------------------------------------------------- decode
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sext     = 1'b0;
        case (mem_aluop_i)
            EXE_LB:  begin is_load = 1'b1; sz_byte = 1'b1; sext = 1'b1; end
            EXE_LBU: begin is_load = 1'b1; sz_byte = 1'b1; end
            EXE_LH:  begin is_load = 1'b1; sz_half = 1'b1; sext = 1'b1; end
            EXE_LHU: begin is_load = 1'b1; sz_half = 1'b1; end
            EXE_LW:  is_load = 1'b1;
            EXE_SB:  begin is_store = 1'b1; sz_byte = 1'b1; end
            EXE_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
            EXE_SW:  is_store = 1'b1;
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;

    // Word accesses need both low bits clear, halfwords only bit 0.
    assign misaligned = is_mem &&
                        ((sz_half && mem_addr_i[0]) ||
                         (!sz_byte && !sz_half && (mem_addr_i[1:0] != 2'b00)));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = mem_reg2_i;
        if (sz_byte) begin
            be_d    = 4'b0001 << mem_addr_i[1:0];
            wdata_d = {4{mem_reg2_i[7:0]}};
        end else if (sz_half) begin
            be_d    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{mem_reg2_i[15:0]}};
        end
    end

    // ---------------------------------------------------------------- load extraction
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        if (sz_byte_q)
            load_data = {{24{sext_q & byte_sel[7]}}, byte_sel};
        else if (sz_half_q)
            load_data = {{16{sext_q & half_sel[15]}}, half_sel};
        else
            load_data = rdata_q;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        wd_o       = mem_wd_i;
        wreg_o     = mem_wreg_i;
        wdata_o    = mem_wdata_i;
        case (state)
            S_IDLE: begin
                if (misaligned) begin
                    misalign_o = 1'b1;
                    wreg_o     = 1'b0;
                end else if (is_mem) begin
                    stallreq_o = 1'b1;
                    state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                stallreq_o = 1'b1;
                if (dbus_ack_i || (to_cnt == TO_LAST))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                bus_err_o = err_q;
                if (err_q) begin
                    wreg_o  = 1'b0;
                    wdata_o = 32'd0;
                end else if (ld_q) begin
                    wdata_o = load_data;
                end
                if (!wb_stall_i)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // While reset is held the stage is transparent and raises no flags.
        if (rst) begin
            stallreq_o = 1'b0;
            misalign_o = 1'b0;
            bus_err_o  = 1'b0;
            wreg_o     = mem_wreg_i;
            wdata_o    = mem_wdata_i;
        end
    end

    // Bus handshake: dbus_req_o is high for the whole REQ state with every bus
    // field held stable; the transfer completes on the first cycle dbus_ack_i is
    // seen while dbus_req_o=1, and dbus_err_i/dbus_rdata_i are only valid then.
    assign dbus_req_o = (state == S_REQ);
    assign dbg_state  = state;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt       <= 8'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            ld_q         <= 1'b0;
            sz_byte_q    <= 1'b0;
            sz_half_q    <= 1'b0;
            sext_q       <= 1'b0;
            addr_lo_q    <= 2'd0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= 32'd0;
            dbus_be_o    <= 4'd0;
            dbus_wdata_o <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mem && !misaligned) begin
                        to_cnt       <= 8'd0;
                        err_q        <= 1'b0;
                        ld_q         <= is_load;
                        sz_byte_q    <= sz_byte;
                        sz_half_q    <= sz_half;
                        sext_q       <= sext;
                        addr_lo_q    <= mem_addr_i[1:0];
                        dbus_we_o    <= is_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_be_o    <= be_d;
                        dbus_wdata_o <= wdata_d;
                    end
                end
                S_REQ: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (dbus_ack_i) begin
                        rdata_q <= dbus_rdata_i;
                        err_q   <= dbus_err_i;
                    end else if (to_cnt == TO_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
